// File: rtl/rc_pulse_stimulus_pkg.sv
// Shared types and defaults for the RC pulse stimulus generator.
package rc_stim_pkg;
  localparam int WIDTH    = 25;
  localparam int EXPONENT = -16;
  localparam int CNT_W    = 16;
  localparam int PER_W    = 8;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  // A zero-length phase would never terminate cleanly, so it is run as one cycle.
  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] x);
    return (x == '0) ? CNT_W'(1) : x;
  endfunction
endpackage

// File: rtl/rc_pulse_stimulus_if.sv
// Control/config and waveform bundle between a sequencer and the stimulus generator.
interface rc_pulse_stimulus_if
  import rc_stim_pkg::*;
#(
  parameter int IW = WIDTH,
  parameter int IC = CNT_W,
  parameter int IP = PER_W
);
  logic                 start;
  logic                 abort;
  logic [IC-1:0]        high_cycles;
  logic [IC-1:0]        low_cycles;
  logic [IP-1:0]        num_periods;
  logic signed [IW-1:0] v_high_code;
  logic signed [IW-1:0] v_low_code;
  logic signed [IW-1:0] v_in;
  logic                 phase_edge;
  logic                 busy;
  logic                 done;

  modport master (
    output start, abort, high_cycles, low_cycles, num_periods, v_high_code, v_low_code,
    input  v_in, phase_edge, busy, done
  );
  modport slave (
    input  start, abort, high_cycles, low_cycles, num_periods, v_high_code, v_low_code,
    output v_in, phase_edge, busy, done
  );
endinterface

// File: rtl/rc_pulse_stimulus_phase_counter.sv
// Phase-length down-counter shared by the HIGH and LOW phases.
module rc_stim_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  input  logic             tick,
  output logic             terminal
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)                      r_cnt <= '0;
    else if (load)                 r_cnt <= len;
    else if (tick && r_cnt != '0)  r_cnt <= r_cnt - CNT_W'(1);
  end

  assign terminal = (r_cnt == '0);
endmodule

// File: rtl/rc_pulse_stimulus.sv
// Pulse-train v_in generator for the RC model harness: HIGH/LOW phases x num_periods.
module rc_pulse_stimulus
  import rc_stim_pkg::*;
#(
  parameter int WIDTH    = rc_stim_pkg::WIDTH,
  parameter int EXPONENT = rc_stim_pkg::EXPONENT,
  parameter int CNT_W    = rc_stim_pkg::CNT_W,
  parameter int PER_W    = rc_stim_pkg::PER_W
) (
  input  logic                clk,
  input  logic                rst,
  rc_pulse_stimulus_if.slave  bus
);
  state_t                  r_state;
  logic [CNT_W-1:0]        r_high, r_low;
  logic [PER_W-1:0]        r_np, r_per;
  logic signed [WIDTH-1:0] r_vhi, r_vlo, r_v_in;
  logic                    r_pe, r_busy, r_done;

  logic                    w_load, w_tick, w_term;
  logic [CNT_W-1:0]        w_len;

  // Counter is reloaded with length-1 on each phase entry; abort just leaves it stale.
  always_comb begin
    w_load = 1'b0;
    w_len  = '0;
    case (r_state)
      IDLE: if (bus.start && bus.num_periods != '0) begin
        w_load = 1'b1;
        w_len  = eff_len(bus.high_cycles) - CNT_W'(1);
      end
      HIGH: if (!bus.abort && w_term) begin
        w_load = 1'b1;
        w_len  = eff_len(r_low) - CNT_W'(1);
      end
      LOW: if (!bus.abort && w_term && r_per < r_np) begin
        w_load = 1'b1;
        w_len  = eff_len(r_high) - CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign w_tick = (r_state == HIGH) || (r_state == LOW);

  rc_stim_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .len      (w_len),
    .tick     (w_tick),
    .terminal (w_term)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_high  <= '0;
      r_low   <= '0;
      r_np    <= '0;
      r_per   <= '0;
      r_vhi   <= '0;
      r_vlo   <= '0;
      r_v_in  <= '0;
      r_pe    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_pe   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_high <= bus.high_cycles;
          r_low  <= bus.low_cycles;
          r_np   <= bus.num_periods;
          r_vhi  <= bus.v_high_code;
          r_vlo  <= bus.v_low_code;
          if (bus.num_periods == '0) begin
            // Empty run: v_in is left untouched, only the done pulse is produced.
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= HIGH;
            r_v_in  <= bus.v_high_code;
            r_pe    <= 1'b1;
            r_busy  <= 1'b1;
            r_per   <= PER_W'(1);
          end
        end
        HIGH: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_v_in  <= r_vlo;
            r_busy  <= 1'b0;
          end else if (w_term) begin
            r_state <= LOW;
            r_v_in  <= r_vlo;
            r_pe    <= 1'b1;
          end
        end
        LOW: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_v_in  <= r_vlo;
            r_busy  <= 1'b0;
          end else if (w_term) begin
            if (r_per < r_np) begin
              r_state <= HIGH;
              r_v_in  <= r_vhi;
              r_pe    <= 1'b1;
              r_per   <= r_per + PER_W'(1);
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.v_in       = r_v_in;
  assign bus.phase_edge = r_pe;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule

// File: doc/rc_pulse_stimulus.md
Name: rc_pulse_stimulus

Overview:
- Drive end of the RC model harness: generates the fixed-point v_in waveform that rc_model consumes. Output-side comparison logic checks v_out against this waveform.
- Produces a programmable pulse train: num_periods periods, each a HIGH phase then a LOW phase, with cycle-exact phase lengths.
- Uses a start/busy/done handshake, so a checker or testbench sequencer can launch runs back to back.
- v_in is a raw signed fixed-point code in the same real format as the model port (WIDTH bits, EXPONENT scale).

Parameters:
- WIDTH, 25, bit width of the signed fixed-point v_in code.
- EXPONENT, -16, binary exponent of v_in; informational, passed alongside v_in to the model, no arithmetic done here.
- CNT_W, 16, width of the phase-length fields and counter.
- PER_W, 8, width of the period-count field.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low; rst==0 at a rising clk edge resets the block.
- start  in  1  request a run; sampled only in IDLE.
- abort  in  1  terminate the run in progress.
- high_cycles  in  CNT_W  HIGH phase length in clk cycles.
- low_cycles  in  CNT_W  LOW phase length in clk cycles.
- num_periods  in  PER_W  number of HIGH+LOW periods.
- v_high_code  in  WIDTH  signed code driven during HIGH.
- v_low_code  in  WIDTH  signed code driven during LOW, DONE and idle-after-run.
- v_in  out  WIDTH  signed stimulus code to rc_model.
- phase_edge  out  1  one-cycle pulse on the first cycle of every HIGH and every LOW phase.
- busy  out  1  high in HIGH and LOW.
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset (rst==0):
  - state=IDLE; v_in=0, busy=0, done=0, phase_edge=0.
  - Counters and latched config cleared.
  - Reset asserted mid-run wins over every other input and takes effect the same edge.
- States are IDLE, HIGH, LOW, DONE.
- IDLE:
  - v_in holds its last value (0 after reset).
  - When start=1, latch all config inputs at that edge. Inputs changing mid-run have no effect.
  - With num_periods==0, the next state is DONE and no HIGH is driven.
  - Otherwise the next state is HIGH.
- Phase lengths: high_cycles==0 or low_cycles==0 is treated as 1.
- HIGH:
  - The first cycle comes one cycle after start is sampled.
  - On that cycle v_in=v_high_code and phase_edge=1.
  - HIGH lasts exactly max(high_cycles,1) cycles, then moves to LOW.
- LOW:
  - v_in=v_low_code; phase_edge=1 on its first cycle.
  - LOW lasts max(low_cycles,1) cycles.
  - If the period index is below num_periods, the next state is HIGH.
  - Otherwise the next state is DONE.
- DONE:
  - Exactly one cycle; done=1, busy=0, v_in=v_low_code. Then IDLE.
- Latency from start to done: 1 + num_periods*(H+L) cycles, with H and L after the zero-to-1 substitution. done is high on the final cycle.
- abort:
  - When abort=1 in HIGH or LOW, the next state is IDLE and v_in=v_low_latched.
  - No done pulse; busy=0 next cycle.
  - abort in IDLE or DONE is ignored.
  - If abort and start are both high in IDLE, start is taken.
  - abort beats a phase transition on the same edge.
- start while busy or in DONE is ignored. No queueing.
- Counter:
  - Down-counter loaded with length-1 on phase entry; the phase ends when the count is 0.
  - Period index counts up and is compared with the latched num_periods (PER_W bits, no wrap, max 255 periods).
- v_in is a register output with no combinational path from any input.

Decomposition:
- Package rc_stim_pkg:
  - state_t enum {IDLE, HIGH, LOW, DONE}.
  - Default WIDTH/EXPONENT/CNT_W/PER_W localparams.
  - Function eff_len(x) returning max(x,1).
- Sub-module rc_stim_phase_counter (CNT_W):
  - Ports: load, len, tick, terminal.
  - Down-counter with synchronous active-low rst.
  - terminal=1 when the count is 0.
  - Instantiated once and reused for both phases.

Test Plan:
- Reset: hold rst=0 three cycles with start=1 -> v_in=0, busy=0, done=0, no HIGH entered.
- Basic run, high=3, low=2, periods=2, v_high=65536 (1.0), v_low=0:
  - v_in sequence 65536 x3, 0 x2, 65536 x3, 0 x2 starting one cycle after start.
  - phase_edge at cycles 1, 4, 6, 9.
  - done at cycle 11.
- Zero fields:
  - periods=0 -> done one cycle after start, v_in unchanged.
  - high=0, low=0, periods=1 -> one HIGH cycle, one LOW cycle, done at cycle 3.
- Abort on the second HIGH cycle -> IDLE next cycle, v_in=v_low, busy=0, no done pulse. A following start runs normally.
- Ignored inputs:
  - start pulsed mid-run has no effect.
  - Config inputs changed mid-run do not alter the waveform.
  - rst=0 on the fourth cycle of a run -> all outputs at reset values next cycle.
- Integration: drive rc_model instances in full and short real formats with a step from 0 to 1.0. Their outputs must satisfy the existing equality property through the whole run.
